sc_period_meter: RTL and testbench

//  Receive-side counterpart of the team's programmable tick generator.
//  - Samples an active-low pulse train and measures the clock cycles between consecutive pulse starts.
//  - Publishes each measurement with a one-cycle valid strobe, flags lock (two equal consecutive periods)
//    and flags overflow (no pulse within the counter range).
//  - Sits beside tick sources for self-check and for rate detection on board-level pulse inputs.

---
 rtl/sc_period_meter.sv | 136 +++++++++++++
 tb/tb_sc_period_meter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/sc_period_meter.sv
// Active-low pulse train period meter: counts clock cycles between pulse starts, flags lock and overflow.
// Optional input synchronizer enabled by defining SC_PERIODMETER_SYNC_EN.
module sc_period_meter #(
  parameter int unsigned METER_DATAWIDTH = 8
) (
  input  logic                       SC_PERIODMETER_CLOCK_50,
  input  logic                       SC_PERIODMETER_RESET_InHigh,
  input  logic                       SC_PERIODMETER_signal_InLow,
  output logic [METER_DATAWIDTH-1:0] SC_PERIODMETER_period_OutBUS,
  output logic                       SC_PERIODMETER_valid_OutHigh,
  output logic                       SC_PERIODMETER_locked_OutHigh,
  output logic                       SC_PERIODMETER_overflow_OutHigh
);

  localparam int unsigned W = METER_DATAWIDTH;
  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    OVRF    = 2'd2
  } state_t;

  logic         clk;
  logic         rst;
  logic         sig_s;
  logic         edge_c;

  state_t       state_q,    state_d;
  logic [W-1:0] count_q,    count_d;
  logic [W-1:0] prev_q,     prev_d;
  logic [W-1:0] period_q,   period_d;
  logic         valid_q,    valid_d;
  logic         locked_q,   locked_d;
  logic         overflow_q, overflow_d;
  logic         last_q,     last_d;

  assign clk = SC_PERIODMETER_CLOCK_50;
  assign rst = SC_PERIODMETER_RESET_InHigh;

`ifdef SC_PERIODMETER_SYNC_EN
  // Two-stage synchronizer; resets high so no false edge leaves reset.
  logic [1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[0], SC_PERIODMETER_signal_InLow};
  end

  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= sync_d;
  end

  assign sig_s = sync_q[1];
`else
  assign sig_s = SC_PERIODMETER_signal_InLow;
`endif

  // A falling edge starts a pulse; a held low never re-triggers.
  assign edge_c = last_q & ~sig_s;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    prev_d     = prev_q;
    period_d   = period_q;
    valid_d    = 1'b0;
    locked_d   = locked_q;
    overflow_d = overflow_q;
    last_d     = sig_s;

    case (state_q)
      IDLE: begin
        if (edge_c) begin
          count_d = W'(1);
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (edge_c) begin
          period_d   = count_q;
          valid_d    = 1'b1;
          locked_d   = (count_q == prev_q) && (prev_q != '0);
          prev_d     = count_q;
          overflow_d = 1'b0;
          count_d    = W'(1);
        end else if (count_q == CNT_MAX) begin
          overflow_d = 1'b1;
          locked_d   = 1'b0;
          prev_d     = '0;
          state_d    = OVRF;
        end else begin
          count_d = count_q + W'(1);
        end
      end
      OVRF: begin
        // Re-arm only; the interval that overflowed is not reported.
        if (edge_c) begin
          count_d = W'(1);
          state_d = MEASURE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      prev_q     <= '0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      overflow_q <= 1'b0;
      last_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      prev_q     <= prev_d;
      period_q   <= period_d;
      valid_q    <= valid_d;
      locked_q   <= locked_d;
      overflow_q <= overflow_d;
      last_q     <= last_d;
    end
  end

  assign SC_PERIODMETER_period_OutBUS    = period_q;
  assign SC_PERIODMETER_valid_OutHigh    = valid_q;
  assign SC_PERIODMETER_locked_OutHigh   = locked_q;
  assign SC_PERIODMETER_overflow_OutHigh = overflow_q;

endmodule

// File: tb/tb_sc_period_meter.sv
// Directed bench for sc_period_meter: lock, spacing changes, long lows, overflow and mid-run reset.
module tb_sc_period_meter;

  localparam int unsigned W = 8;
`ifdef SC_PERIODMETER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         sig;
  logic [W-1:0] period;
  logic         valid;
  logic         locked;
  logic         overflow;

  int n_checks = 0;
  int n_errors = 0;

  sc_period_meter #(.METER_DATAWIDTH(W)) dut (
    .SC_PERIODMETER_CLOCK_50         (clk),
    .SC_PERIODMETER_RESET_InHigh     (rst),
    .SC_PERIODMETER_signal_InLow     (sig),
    .SC_PERIODMETER_period_OutBUS    (period),
    .SC_PERIODMETER_valid_OutHigh    (valid),
    .SC_PERIODMETER_locked_OutHigh   (locked),
    .SC_PERIODMETER_overflow_OutHigh (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One pulse of low_len cycles, then high until gap cycles have elapsed.
  // Expectations describe the capture triggered by this pulse's start edge.
  task automatic run_pulse(input string tag, input int gap, input int low_len,
                           input bit exp_valid, input int exp_period,
                           input bit exp_locked, input bit exp_ovf);
    int stray = 0;
    for (int i = 0; i < gap; i++) begin
      sig = (i < low_len) ? 1'b0 : 1'b1;
      tick();
      if (i == LAT) begin
        check_eq({tag, ".valid"}, int'(valid), int'(exp_valid));
        if (exp_valid) begin
          check_eq({tag, ".period"}, int'(period), exp_period);
        end
        check_eq({tag, ".locked"}, int'(locked), int'(exp_locked));
        check_eq({tag, ".overflow"}, int'(overflow), int'(exp_ovf));
      end else if (valid) begin
        stray++;
      end
    end
    check_eq({tag, ".extra_valids"}, stray, 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, ".period"},   int'(period),   0);
    check_eq({tag, ".valid"},    int'(valid),    0);
    check_eq({tag, ".locked"},   int'(locked),   0);
    check_eq({tag, ".overflow"}, int'(overflow), 0);
  endtask

  initial begin
    rst = 1'b1;
    sig = 1'b1;
    tick();
    tick();
    check_outputs_zero("reset");
    rst = 1'b0;
    tick();
    check_outputs_zero("idle");

    // Steady 10-cycle spacing: arm, then capture, then lock.
    run_pulse("s1_p1", 10, 1, 1'b0, 0,  1'b0, 1'b0);
    run_pulse("s1_p2", 10, 1, 1'b1, 10, 1'b0, 1'b0);
    run_pulse("s1_p3", 10, 1, 1'b1, 10, 1'b1, 1'b0);

    // Spacing change 10 -> 5 -> 5.
    run_pulse("s2_p1", 5, 1, 1'b1, 10, 1'b1, 1'b0);
    run_pulse("s2_p2", 5, 1, 1'b1, 5,  1'b0, 1'b0);
    run_pulse("s2_p3", 5, 1, 1'b1, 5,  1'b1, 1'b0);

    // Three-cycle low runs at period 8.
    run_pulse("s4_p1", 8, 3, 1'b1, 5, 1'b1, 1'b0);
    run_pulse("s4_p2", 8, 3, 1'b1, 8, 1'b0, 1'b0);
    run_pulse("s4_p3", 8, 3, 1'b1, 8, 1'b1, 1'b0);

    // Counter limit: 255 captures, 256 overflows, then recovery.
    run_pulse("s3_p1", 255, 1, 1'b1, 8,   1'b1, 1'b0);
    run_pulse("s3_p2", 256, 1, 1'b1, 255, 1'b0, 1'b0);
    run_pulse("s3_p3", 12,  1, 1'b0, 0,   1'b0, 1'b1);
    run_pulse("s3_p4", 10,  1, 1'b1, 12,  1'b0, 1'b0);

    // Reset four cycles into a measurement.
    sig = 1'b0;
    tick();
    sig = 1'b1;
    for (int i = 0; i < 3 + LAT; i++) tick();
    rst = 1'b1;
    tick();
    check_outputs_zero("s5_rst");
    rst = 1'b0;
    tick();
    check_outputs_zero("s5_post");
    run_pulse("s5_p1", 7, 1, 1'b0, 0, 1'b0, 1'b0);
    run_pulse("s5_p2", 7, 1, 1'b1, 7, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
